// File: rtl/debug_rom_ctrl_if.sv
// Request/response bus between a debug fetch/load master and the debug ROM controller.
// Latency: none (wires only).
// Backpressure: requests stall on gnt_o; responses stall on rready_i.
// Ports: master drives req_i/we_i/addr_i/rready_i, slave drives gnt_o/rvalid_o/rdata_o/rerr_o.
interface debug_rom_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic              rready_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rerr_o;

  modport master (
    output req_i, we_i, addr_i, rready_i,
    input  gnt_o, rvalid_o, rdata_o, rerr_o
  );

  modport slave (
    input  req_i, we_i, addr_i, rready_i,
    output gnt_o, rvalid_o, rdata_o, rerr_o
  );
endinterface

// File: rtl/debug_rom_ctrl.sv
// Debug ROM controller: decodes addresses against BASE_ADDR and returns ROM words or error responses in order.
// Latency: response visible the cycle after the transfer when nothing older is pending.
// Backpressure: at most OUT_DEPTH requests outstanding; gnt_o drops when full, head held while rready_i is low.
// Ports: clk_i/rst_ni (async, active-low), image_i (ROM contents, word k at k*DATA_W), bus (slave side of debug_rom_ctrl_if).
module debug_rom_ctrl #(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       ROM_WORDS = 20,
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h800,
  parameter int unsigned       OUT_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [ROM_WORDS*DATA_W-1:0]   image_i,
  debug_rom_ctrl_if.slave               bus
);

  localparam int unsigned OFF_B = $clog2(DATA_W / 8);
  localparam int unsigned IW    = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int unsigned PW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW    = $clog2(OUT_DEPTH + 1);

  // ROM view of the flat image
  logic [DATA_W-1:0] rom [ROM_WORDS];
  for (genvar k = 0; k < ROM_WORDS; k++) begin : g_rom
    assign rom[k] = image_i[k*DATA_W +: DATA_W];
  end

  // Address decode
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx_full;
  logic              dec_err;
  logic [IW-1:0]     dec_idx;

  always_comb begin
    off      = bus.addr_i - BASE_ADDR;
    idx_full = off >> OFF_B;
    dec_err  = (bus.addr_i < BASE_ADDR)
            || (idx_full >= ADDR_W'(ROM_WORDS))
            || (off[OFF_B-1:0] != '0)
            || bus.we_i;
    // Erroring requests store index 0 so the ROM read below stays in range.
    dec_idx  = dec_err ? '0 : IW'(idx_full);
  end

  // Credit-based grant: stage 1 plus queue may never exceed OUT_DEPTH.
  logic [CW-1:0] outstanding;
  logic          transfer;
  logic          pop;

  assign bus.gnt_o = bus.req_i && (outstanding < CW'(OUT_DEPTH));
  assign transfer  = bus.req_i && bus.gnt_o;

  // Stage 1: registered decode result
  logic          s1_vld;
  logic          s1_err;
  logic [IW-1:0] s1_idx;
  logic [DATA_W-1:0] s1_word;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld <= 1'b0;
      s1_err <= 1'b0;
      s1_idx <= '0;
    end else begin
      s1_vld <= transfer;
      if (transfer) begin
        s1_err <= dec_err;
        s1_idx <= dec_idx;
      end
    end
  end

  assign s1_word = s1_err ? '0 : rom[s1_idx];

  // Response queue of {rerr, rdata}
  logic [DATA_W:0] q_mem [OUT_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   q_count;
  logic            q_empty;
  logic            q_full;
  logic            q_push;
  logic            q_pop;
  logic [DATA_W:0] head;

  assign q_empty = (q_count == '0);
  assign q_full  = (q_count == CW'(OUT_DEPTH));

  // When the queue is empty the stage-1 word is presented directly, which
  // gives the one-cycle latency; it is newer than any queued entry, so this
  // never reorders responses.
  always_comb begin
    head = '0;
    if (!q_empty) begin
      head = q_mem[rd_ptr];
    end else if (s1_vld) begin
      head = {s1_err, s1_word};
    end
  end

  assign bus.rvalid_o = !q_empty || s1_vld;
  assign bus.rerr_o   = head[DATA_W];
  assign bus.rdata_o  = head[DATA_W-1:0];

  assign pop    = bus.rvalid_o && bus.rready_i;
  assign q_pop  = pop && !q_empty;
  // The stage-1 word is enqueued unless it was consumed straight from stage 1.
  assign q_push = s1_vld && !(pop && q_empty);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (q_push) wr_ptr <= ptr_inc(wr_ptr);
      if (q_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({q_push, q_pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (q_push) q_mem[wr_ptr] <= {s1_err, s1_word};
  end

  // Outstanding counter: stage-1 entries plus queued entries
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({transfer, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // The credit rule makes queue overflow impossible.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(q_push && q_full && !q_pop));
    end
  end

endmodule

// File: tb/tb_debug_rom_ctrl.sv
// Directed self-checking bench for debug_rom_ctrl (64-bit and 32-bit configurations).
// Latency: inputs driven on the falling edge, outputs sampled on/after the falling edge.
// Backpressure: exercised by holding rready_i low with requests pending.
module tb_debug_rom_ctrl;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [20*64-1:0] img64;
  logic [8*32-1:0]  img32;

  debug_rom_ctrl_if #(.DATA_W(64), .ADDR_W(64)) bus64 ();
  debug_rom_ctrl_if #(.DATA_W(32), .ADDR_W(64)) bus32 ();

  debug_rom_ctrl #(
    .DATA_W(64), .ROM_WORDS(20), .ADDR_W(64), .BASE_ADDR(64'h800), .OUT_DEPTH(2)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .image_i (img64),
    .bus     (bus64)
  );

  debug_rom_ctrl #(
    .DATA_W(32), .ROM_WORDS(8), .ADDR_W(64), .BASE_ADDR(64'h800), .OUT_DEPTH(2)
  ) dut32 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .image_i (img32),
    .bus     (bus32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  function automatic logic [63:0] w64(input int k);
    return 64'hD0D0_0000_0000_0000 + 64'(k);
  endfunction

  initial begin
    for (int k = 0; k < 20; k++) img64[k*64 +: 64] = w64(k);
    for (int k = 0; k < 8; k++)  img32[k*32 +: 32] = 32'hCAFE_0000 + 32'(k);

    bus64.req_i = 1'b0; bus64.we_i = 1'b0; bus64.addr_i = '0; bus64.rready_i = 1'b1;
    bus32.req_i = 1'b0; bus32.we_i = 1'b0; bus32.addr_i = '0; bus32.rready_i = 1'b1;

    // Reset state
    step(); step();
    chk("rst_rvalid", 64'(bus64.rvalid_o), 64'd0);
    chk("rst_rdata",  bus64.rdata_o, 64'd0);
    chk("rst_rerr",   64'(bus64.rerr_o), 64'd0);
    chk("rst_gnt",    64'(bus64.gnt_o), 64'd0);
    rst_ni = 1'b1;
    step();

    // 1. Single read
    bus64.req_i = 1'b1; bus64.addr_i = 64'h818;
    #1 chk("t1_gnt", 64'(bus64.gnt_o), 64'd1);
    step();
    bus64.req_i = 1'b0;
    #1 chk("t1_gnt_idle", 64'(bus64.gnt_o), 64'd0);
    chk("t1_rvalid", 64'(bus64.rvalid_o), 64'd1);
    chk("t1_rdata",  bus64.rdata_o, 64'hD0D0_0000_0000_0003);
    chk("t1_rerr",   64'(bus64.rerr_o), 64'd0);
    step();
    chk("t1_rvalid_after", 64'(bus64.rvalid_o), 64'd0);

    // 2. Error responses
    begin
      logic [63:0] eaddr [4];
      logic        ewe   [4];
      eaddr[0] = 64'h7F8; ewe[0] = 1'b0;
      eaddr[1] = 64'h8A0; ewe[1] = 1'b0;
      eaddr[2] = 64'h804; ewe[2] = 1'b0;
      eaddr[3] = 64'h800; ewe[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        bus64.req_i = 1'b1; bus64.we_i = ewe[i]; bus64.addr_i = eaddr[i];
        #1 chk($sformatf("t2_gnt%0d", i), 64'(bus64.gnt_o), 64'd1);
        step();
        bus64.req_i = 1'b0; bus64.we_i = 1'b0;
        chk($sformatf("t2_rvalid%0d", i), 64'(bus64.rvalid_o), 64'd1);
        chk($sformatf("t2_rerr%0d", i),   64'(bus64.rerr_o), 64'd1);
        chk($sformatf("t2_rdata%0d", i),  bus64.rdata_o, 64'd0);
      end
      step();
      chk("t2_idle", 64'(bus64.rvalid_o), 64'd0);
    end

    // 3. Backpressure and credit limit
    bus64.rready_i = 1'b0;
    bus64.req_i = 1'b1; bus64.addr_i = 64'h800;
    #1 chk("t3_gnt0", 64'(bus64.gnt_o), 64'd1);
    step();
    bus64.addr_i = 64'h808;
    #1 chk("t3_gnt1", 64'(bus64.gnt_o), 64'd1);
    step();
    bus64.addr_i = 64'h810;
    #1 chk("t3_gnt2_blocked", 64'(bus64.gnt_o), 64'd0);
    chk("t3_head0", bus64.rdata_o, w64(0));
    step();
    #1 chk("t3_gnt2_still_blocked", 64'(bus64.gnt_o), 64'd0);
    chk("t3_head0_held", bus64.rdata_o, w64(0));
    chk("t3_rvalid_held", 64'(bus64.rvalid_o), 64'd1);
    bus64.rready_i = 1'b1;
    #1 chk("t3_no_bypass", 64'(bus64.gnt_o), 64'd0);
    step();
    #1 chk("t3_head1", bus64.rdata_o, w64(1));
    chk("t3_gnt2_after_pop", 64'(bus64.gnt_o), 64'd1);
    step();
    bus64.req_i = 1'b0;
    chk("t3_rvalid2", 64'(bus64.rvalid_o), 64'd1);
    chk("t3_head2", bus64.rdata_o, w64(2));
    step();
    chk("t3_idle", 64'(bus64.rvalid_o), 64'd0);

    // 4. Streaming all 20 words
    for (int i = 0; i < 20; i++) begin
      step();
      bus64.req_i = 1'b1; bus64.addr_i = 64'h800 + 64'(8 * i);
      #1 chk($sformatf("t4_gnt%0d", i), 64'(bus64.gnt_o), 64'd1);
      if (i > 0) begin
        chk($sformatf("t4_rvalid%0d", i - 1), 64'(bus64.rvalid_o), 64'd1);
        chk($sformatf("t4_rdata%0d", i - 1), bus64.rdata_o, w64(i - 1));
      end
    end
    step();
    bus64.req_i = 1'b0;
    chk("t4_rvalid19", 64'(bus64.rvalid_o), 64'd1);
    chk("t4_rdata19", bus64.rdata_o, w64(19));
    step();
    chk("t4_idle", 64'(bus64.rvalid_o), 64'd0);

    // 5. Reset with two requests outstanding
    bus64.rready_i = 1'b0;
    bus64.req_i = 1'b1; bus64.addr_i = 64'h800;
    step();
    bus64.addr_i = 64'h808;
    step();
    bus64.req_i = 1'b0;
    chk("t5_pending", 64'(bus64.rvalid_o), 64'd1);
    rst_ni = 1'b0;
    #1 chk("t5_rst_rvalid", 64'(bus64.rvalid_o), 64'd0);
    chk("t5_rst_rdata", bus64.rdata_o, 64'd0);
    step();
    rst_ni = 1'b1;
    step();
    chk("t5_no_stale0", 64'(bus64.rvalid_o), 64'd0);
    bus64.rready_i = 1'b1;
    step();
    chk("t5_no_stale1", 64'(bus64.rvalid_o), 64'd0);
    bus64.req_i = 1'b1; bus64.addr_i = 64'h808;
    #1 chk("t5_gnt", 64'(bus64.gnt_o), 64'd1);
    step();
    bus64.req_i = 1'b0;
    chk("t5_rvalid", 64'(bus64.rvalid_o), 64'd1);
    chk("t5_rdata", bus64.rdata_o, w64(1));
    chk("t5_rerr", 64'(bus64.rerr_o), 64'd0);

    // 6. 32-bit configuration
    step();
    bus32.req_i = 1'b1; bus32.addr_i = 64'h80C;
    #1 chk("t6_gnt", 64'(bus32.gnt_o), 64'd1);
    step();
    bus32.addr_i = 64'h802;
    chk("t6_rdata", 64'(bus32.rdata_o), 64'hCAFE_0003);
    chk("t6_rerr_ok", 64'(bus32.rerr_o), 64'd0);
    step();
    bus32.req_i = 1'b0;
    chk("t6_err_rvalid", 64'(bus32.rvalid_o), 64'd1);
    chk("t6_err_rerr", 64'(bus32.rerr_o), 64'd1);
    chk("t6_err_rdata", 64'(bus32.rdata_o), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
